// File: rtl/button_conditioner.sv
// Pushbutton and switch front end: two-flop synchronizers, optional per-key debounce FSM
// (compiled in when BUTTON_DEBOUNCE_EN is defined) and a rising-edge pulse for Execute.
module button_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = $clog2(DB_CYCLES) + 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       KeyExec_n,
    input  logic       KeyLdA_n,
    input  logic       KeyLdB_n,
    input  logic [7:0] SW,
    output logic       Execute,
    output logic       LoadA,
    output logic       LoadB,
    output logic       Exec_Rise,
    output logic [7:0] Din
);

    localparam int NKEY = 3;

    // Channel order: 0 = Execute, 1 = LoadA, 2 = LoadB; keys are inverted so pressed = 1
    logic [NKEY-1:0] key_pressed;
    logic [NKEY-1:0] key_sync1_reg;
    logic [NKEY-1:0] key_sync2_reg;
    logic [NKEY-1:0] key_level;
    logic [7:0]      sw_sync1_reg;
    logic [7:0]      sw_sync2_reg;
    logic            exec_prev_reg;

    assign key_pressed = ~{KeyLdB_n, KeyLdA_n, KeyExec_n};

    genvar gi;

    generate
        for (gi = 0; gi < NKEY; gi++) begin : g_key_sync
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    key_sync1_reg[gi] <= 1'b0;
                    key_sync2_reg[gi] <= 1'b0;
                end else begin
                    key_sync1_reg[gi] <= key_pressed[gi];
                    key_sync2_reg[gi] <= key_sync1_reg[gi];
                end
            end
        end

        for (gi = 0; gi < 8; gi++) begin : g_sw_sync
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    sw_sync1_reg[gi] <= 1'b0;
                    sw_sync2_reg[gi] <= 1'b0;
                end else begin
                    sw_sync1_reg[gi] <= SW[gi];
                    sw_sync2_reg[gi] <= sw_sync1_reg[gi];
                end
            end
        end
    endgenerate

`ifdef BUTTON_DEBOUNCE_EN
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        HELD_HI = 2'd2,
        CHK_LO  = 2'd3
    } db_state_t;

    // The count holds samples already seen; the DB_CYCLES-th agreeing sample commits the change
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_FULL = DB_W'(DB_CYCLES);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    generate
        for (gi = 0; gi < NKEY; gi++) begin : g_debounce
            db_state_t       state_reg;
            db_state_t       state_next;
            logic [DB_W-1:0] count_reg;
            logic [DB_W-1:0] count_next;
            logic            sample;

            assign sample = key_sync2_reg[gi];

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    state_reg <= IDLE_LO;
                    count_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                case (state_reg)
                    IDLE_LO: begin
                        if (sample) begin
                            state_next = CHK_HI;
                            count_next = CNT_ONE;
                        end
                    end
                    CHK_HI: begin
                        if (!sample) begin
                            state_next = IDLE_LO;
                            count_next = '0;
                        end else if (count_reg >= CNT_LAST) begin
                            state_next = HELD_HI;
                            count_next = CNT_FULL;
                        end else begin
                            count_next = count_reg + CNT_ONE;
                        end
                    end
                    HELD_HI: begin
                        if (!sample) begin
                            state_next = CHK_LO;
                            count_next = CNT_ONE;
                        end
                    end
                    CHK_LO: begin
                        if (sample) begin
                            state_next = HELD_HI;
                            count_next = '0;
                        end else if (count_reg >= CNT_LAST) begin
                            state_next = IDLE_LO;
                            count_next = CNT_FULL;
                        end else begin
                            count_next = count_reg + CNT_ONE;
                        end
                    end
                    default: begin
                        state_next = IDLE_LO;
                        count_next = '0;
                    end
                endcase
            end

            always_comb begin
                key_level[gi] = (state_reg == HELD_HI) || (state_reg == CHK_LO);
            end
        end
    endgenerate
`else
    assign key_level = key_sync2_reg;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            exec_prev_reg <= 1'b0;
        end else begin
            exec_prev_reg <= key_level[0];
        end
    end

    assign Execute   = key_level[0];
    assign LoadA     = key_level[1];
    assign LoadB     = key_level[2];
    assign Exec_Rise = key_level[0] & ~exec_prev_reg;
    assign Din       = sw_sync2_reg;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4, consecutive stable synchronized samples required before a debounced output changes (legal 2..2^20).
REQ-002 Parameter DB_W, default $clog2(DB_CYCLES)+1, debounce counter width.
REQ-003 Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 KeyExec_n  input  1  raw asynchronous Execute pushbutton, active-low.
REQ-006 KeyLdA_n  input  1  raw asynchronous LoadA pushbutton, active-low.
REQ-007 KeyLdB_n  input  1  raw asynchronous LoadB pushbutton, active-low.
REQ-008 SW  input  8  raw asynchronous operand switches.
REQ-009 Execute  output  1  conditioned Execute level, active-high, held while the key is held.
REQ-010 LoadA  output  1  conditioned LoadA level, active-high.
REQ-011 LoadB  output  1  conditioned LoadB level, active-high.
REQ-012 Exec_Rise  output  1  single-cycle pulse on each 0->1 transition of Execute.
REQ-013 Din  output  8  synchronized SW value.

Function
REQ-014 Each key channel shall pass through a 2-flop synchronizer after inversion (pressed = 1).
REQ-015 SW shall pass through a 2-flop synchronizer per bit, without debounce; Din lags SW by 2 cycles.
REQ-016 Each key channel shall run a 4-state FSM: IDLE_LO, CHK_HI, HELD_HI, CHK_LO; output = 1 in HELD_HI and CHK_LO only.
REQ-017 IDLE_LO: synchronized 1 -> CHK_HI, counter cleared to 1; else remain.
REQ-018 CHK_HI: synchronized 0 -> IDLE_LO (bounce, counter cleared); counter = DB_CYCLES and sample 1 -> HELD_HI; else counter increments.
REQ-019 HELD_HI/CHK_LO: mirror of REQ-017/018 with polarity reversed.
REQ-020 Latency: output shall change exactly DB_CYCLES+2 rising edges after the first edge sampling a raw value that then stays stable.
REQ-021 Any glitch shorter than DB_CYCLES synchronized samples shall produce no output change and shall restart the count.
REQ-022 Exec_Rise shall assert in the cycle Execute first reads 1 and deassert the next cycle; a held key yields exactly one pulse.
REQ-023 Channels shall be independent; simultaneous presses shall each obey REQ-020 with no arbitration.
REQ-024 Counters shall saturate at DB_CYCLES and never wrap.

Reset
REQ-025 Reset shall set all synchronizer flops to the released value (logic 0 after inversion).
REQ-026 Reset shall put every FSM in IDLE_LO and clear every counter.
REQ-027 Reset shall drive Execute, LoadA, LoadB, Exec_Rise and Din to 0 in the cycle after the sampling edge.
REQ-028 Reset mid-count shall discard the count; a key held through reset release shall assert its output DB_CYCLES+2 cycles after the first non-reset edge.

Configuration
REQ-029 Macro BUTTON_DEBOUNCE_EN defined: FSMs and counters of REQ-016..024 shall be compiled in.
REQ-030 BUTTON_DEBOUNCE_EN undefined: each key output shall equal its synchronizer output (2-cycle latency); FSMs, counters and DB_CYCLES shall have no effect; Exec_Rise shall still derive from Execute per REQ-022.

Verification (DB_CYCLES=4, BUTTON_DEBOUNCE_EN defined unless noted)
REQ-031 Reset, then KeyExec_n=0 held -> Execute=1 and Exec_Rise=1 exactly 6 edges later; Exec_Rise=0 the following cycle.
REQ-032 KeyLdA_n low for 3 cycles, then high -> LoadA remains 0 throughout.
REQ-033 Execute held 1, KeyExec_n toggled high 2 cycles then low -> Execute stays 1, no second Exec_Rise.
REQ-034 SW=8'hA5 -> Din=8'hA5 after 2 edges; SW=8'h3C -> Din=8'h3C after 2 edges.
REQ-035 KeyLdB_n low, Reset asserted at count 3 for 1 cycle -> LoadB=0 during reset, LoadB=1 6 edges after release.
REQ-036 BUTTON_DEBOUNCE_EN undefined, KeyExec_n low 1 cycle -> Execute=1 for 1 cycle, 2 edges later, with one Exec_Rise pulse.
